// File: rtl/fnn_pkg.sv
// Shared definitions for the feed-forward network datapath blocks.
package fnn_pkg;

    localparam int FNN_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        SER_IDLE    = 2'd0,
        SER_COLLECT = 2'd1,
        SER_STREAM  = 2'd2
    } ser_state_t;

endpackage

// File: rtl/layer_out_serializer.sv
// Collects one activation per neuron of a layer, then streams the frame one word
// per cycle (index 0 first) onto the next layer's shared input bus.
module layer_out_serializer
    import fnn_pkg::*;
#(
    parameter int NUM_NEURONS = 30,
    parameter int DATA_WIDTH  = FNN_DATA_WIDTH
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_NEURONS*DATA_WIDTH-1:0] neuron_out,
    input  logic [NUM_NEURONS-1:0]            neuron_valid,
    output logic [DATA_WIDTH-1:0]             out_data,
    output logic                              out_valid,
    output logic                              out_last,
    output logic                              busy,
    output logic                              overrun_err
);

    localparam int IDX_W = $clog2(NUM_NEURONS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_NEURONS - 1);

    ser_state_t             state_r;
    logic [NUM_NEURONS-1:0] mask_r;
    logic [IDX_W-1:0]       idx_r;
    logic [DATA_WIDTH-1:0]  word_buf_r [NUM_NEURONS];
    logic [DATA_WIDTH-1:0]  out_data_r;
    logic                   out_valid_r;
    logic                   out_last_r;
    logic                   busy_r;
    logic                   overrun_err_r;

    logic [NUM_NEURONS-1:0] wr_en_s;
    logic                   any_valid_s;
    logic                   mask_full_s;
    logic [IDX_W-1:0]       idx_nxt_s;
    logic [DATA_WIDTH-1:0]  first_word_s;

    // Nothing is written while streaming, so the frame being read stays intact.
    assign wr_en_s      = (state_r == SER_STREAM) ? {NUM_NEURONS{1'b0}} : neuron_valid;
    assign any_valid_s  = |neuron_valid;
    assign mask_full_s  = &(mask_r | neuron_valid);
    assign idx_nxt_s    = idx_r + IDX_W'(1);
    // Word 0 may be captured in the very cycle the frame completes, so bypass it.
    assign first_word_s = neuron_valid[0] ? neuron_out[DATA_WIDTH-1:0] : word_buf_r[0];

    // Activation buffer: per-neuron write enables, deliberately not reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_NEURONS; i++) begin
            if (wr_en_s[i]) begin
                word_buf_r[i] <= neuron_out[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Frame FSM with capture mask, stream index and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= SER_IDLE;
            mask_r        <= {NUM_NEURONS{1'b0}};
            idx_r         <= {IDX_W{1'b0}};
            out_data_r    <= {DATA_WIDTH{1'b0}};
            out_valid_r   <= 1'b0;
            out_last_r    <= 1'b0;
            busy_r        <= 1'b0;
            overrun_err_r <= 1'b0;
        end else begin
            case (state_r)
                SER_IDLE, SER_COLLECT: begin
                    out_valid_r <= 1'b0;
                    out_last_r  <= 1'b0;
                    mask_r      <= mask_r | neuron_valid;
                    if (mask_full_s) begin
                        state_r     <= SER_STREAM;
                        idx_r       <= {IDX_W{1'b0}};
                        out_data_r  <= first_word_s;
                        out_valid_r <= 1'b1;
                        busy_r      <= 1'b1;
                    end else if (any_valid_s) begin
                        state_r <= SER_COLLECT;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= state_r;
                    end
                end
                SER_STREAM: begin
                    if (any_valid_s) begin
                        overrun_err_r <= 1'b1;
                    end
                    // idx_r is the index of the word currently on out_data.
                    if (idx_r == IDX_LAST) begin
                        state_r     <= SER_IDLE;
                        mask_r      <= {NUM_NEURONS{1'b0}};
                        idx_r       <= {IDX_W{1'b0}};
                        out_valid_r <= 1'b0;
                        out_last_r  <= 1'b0;
                        busy_r      <= 1'b0;
                    end else begin
                        idx_r      <= idx_nxt_s;
                        out_data_r <= word_buf_r[idx_nxt_s];
                        out_last_r <= (idx_nxt_s == IDX_LAST);
                    end
                end
                default: begin
                    state_r     <= SER_IDLE;
                    mask_r      <= {NUM_NEURONS{1'b0}};
                    idx_r       <= {IDX_W{1'b0}};
                    out_valid_r <= 1'b0;
                    out_last_r  <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign out_data    = out_data_r;
    assign out_valid   = out_valid_r;
    assign out_last    = out_last_r;
    assign busy        = busy_r;
    assign overrun_err = overrun_err_r;

endmodule
